// File: rtl/deinterl_pkg.sv
// Shared types for the ping-pong block deinterleaver.
//   bank_state_t : occupancy state of one RAM bank
//     EMPTY    - free, may accept the first write of a block
//     FILLING  - partially written
//     FULL     - holds a complete block, no read issued yet
//     DRAINING - reads in progress
package deinterl_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/deinterl_pingpong_if.sv
// Stream interface of the deinterleaver.
//   in_valid/in_ready/in_data     : column-major soft-bit input stream
//   out_valid/out_ready/out_data  : row-major soft-bit output stream
//   out_sof/out_eof               : first/last sample of a block, qualified by out_valid
//   blk_cnt                       : number of blocks fully output (wraps)
// Modports: master = stream source/sink side (bench), slave = deinterleaver.
interface deinterl_pingpong_if #(
  parameter int unsigned SOFT_W = 5
) ();

  logic              in_valid;
  logic              in_ready;
  logic [SOFT_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [SOFT_W-1:0] out_data;
  logic              out_sof;
  logic              out_eof;
  logic [15:0]       blk_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eof, blk_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eof, blk_cnt
  );

endinterface

// File: rtl/deinterl_bank_ram.sv
// Simple dual-port RAM holding both deinterleaver banks.
//   clk, rst : clock; rst clears only the read output register
//   we, waddr, wdata : write port
//   re, raddr, rdata : registered read port, rdata holds while re is low
// The bank select is the address MSB, so bank 1 starts at 2**(RAM_AW-1); the
// array spans the full address range so non-power-of-two blocks stay in range.
module deinterl_bank_ram #(
  parameter int unsigned SOFT_W = 5,
  parameter int unsigned RAM_AW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  logic [SOFT_W-1:0] wdata,
  input  logic              re,
  input  logic [RAM_AW-1:0] raddr,
  output logic [SOFT_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << RAM_AW;

  logic [SOFT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/deinterl_pingpong.sv
// Ping-pong block deinterleaver: writes ROWS x COLS blocks column-major into one
// bank while the other bank is read out row-major.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stream interface (slave modport), see deinterl_pingpong_if
module deinterl_pingpong
  import deinterl_pkg::*;
#(
  parameter int unsigned SOFT_W = 5,
  parameter int unsigned ROWS   = 128,
  parameter int unsigned COLS   = 128
) (
  input logic                clk,
  input logic                rst,
  deinterl_pingpong_if.slave bus
);

  localparam int unsigned N      = ROWS * COLS;
  localparam int unsigned ADDR_W = $clog2(N);
  localparam int unsigned R_W    = $clog2(ROWS);
  localparam int unsigned C_W    = $clog2(COLS);

  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  logic              wb_q, rb_q;
  logic [ADDR_W-1:0] wr_k_q;
  logic [R_W-1:0]    r_q;
  logic [C_W-1:0]    c_q;
  logic [ADDR_W-1:0] rd_addr_q;  // c*ROWS + r, tracked incrementally
  logic              out_valid_q, out_sof_q, out_eof_q;
  logic [15:0]       blk_cnt_q;

  logic              in_ready, wr_fire, wr_last;
  logic              rd_fire, r_last, c_last, rd_last;
  logic [SOFT_W-1:0] rdata;

  assign in_ready = (bank_q[wb_q] == EMPTY) || (bank_q[wb_q] == FILLING);
  assign wr_fire  = bus.in_valid && in_ready;
  assign wr_last  = (wr_k_q == ADDR_W'(N - 1));

  assign r_last  = (r_q == R_W'(ROWS - 1));
  assign c_last  = (c_q == C_W'(COLS - 1));
  assign rd_last = r_last && c_last;
  // Read only when the output register is free or is being consumed this cycle.
  assign rd_fire = ((bank_q[rb_q] == FULL) || (bank_q[rb_q] == DRAINING)) &&
                   (!out_valid_q || bus.out_ready);

  // Bank states: writer and reader never target the same bank, so both updates
  // can be applied independently in one cycle.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      bank_d[i] = bank_q[i];
      if (wr_fire && (wb_q == i[0])) begin
        if (wr_last) begin
          bank_d[i] = FULL;
        end else if (bank_q[i] == EMPTY) begin
          bank_d[i] = FILLING;
        end
      end
      if (rd_fire && (rb_q == i[0])) begin
        if (rd_last) begin
          bank_d[i] = EMPTY;
        end else if (bank_q[i] == FULL) begin
          bank_d[i] = DRAINING;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
    end else begin
      bank_q <= bank_d;
    end
  end

  // Write side
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q   <= 1'b0;
      wr_k_q <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_k_q <= '0;
        wb_q   <= ~wb_q;
      end else begin
        wr_k_q <= wr_k_q + ADDR_W'(1);
      end
    end
  end

  // Read side: c is the fast index; the address steps by ROWS along a row and
  // reloads to r+1 at the end of each row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_q      <= 1'b0;
      r_q       <= '0;
      c_q       <= '0;
      rd_addr_q <= '0;
    end else if (rd_fire) begin
      if (c_last) begin
        c_q <= '0;
        if (r_last) begin
          r_q       <= '0;
          rd_addr_q <= '0;
          rb_q      <= ~rb_q;
        end else begin
          r_q       <= r_q + R_W'(1);
          rd_addr_q <= ADDR_W'(r_q) + ADDR_W'(1);
        end
      end else begin
        c_q       <= c_q + C_W'(1);
        rd_addr_q <= rd_addr_q + ADDR_W'(ROWS);
      end
    end
  end

  // Output flags track the RAM read register one cycle behind the read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else if (rd_fire) begin
      out_valid_q <= 1'b1;
      out_sof_q   <= (r_q == '0) && (c_q == '0);
      out_eof_q   <= rd_last;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && out_eof_q) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  deinterl_bank_ram #(
    .SOFT_W (SOFT_W),
    .RAM_AW (ADDR_W + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire),
    .waddr ({wb_q, wr_k_q}),
    .wdata (bus.in_data),
    .re    (rd_fire),
    .raddr ({rb_q, rd_addr_q}),
    .rdata (rdata)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rdata;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_deinterl_pingpong.sv
// Bench for deinterl_pingpong: a 4x3 instance for the directed/random tests and a
// default 128x128 instance for the full-size block. Each instance has a transpose
// model (queue of whole blocks re-ordered row-major) checked every cycle.
module tb_deinterl_pingpong;

  localparam int SW = 5;
  localparam int SR = 4;
  localparam int SC = 3;
  localparam int SN = SR * SC;
  localparam int BR = 128;
  localparam int BC = 128;
  localparam int BN = BR * BC;

  typedef struct {
    logic [4:0] data;
    bit         sof;
    bit         eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  deinterl_pingpong_if #(.SOFT_W(SW)) bus_s ();
  deinterl_pingpong_if #(.SOFT_W(SW)) bus_b ();

  deinterl_pingpong #(.SOFT_W(SW), .ROWS(SR), .COLS(SC)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  deinterl_pingpong #(.SOFT_W(SW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  exp_t       exp_s[$], exp_b[$];
  logic [4:0] part_s[$], part_b[$];
  int         got_s[$];
  int         mdl_blk_s, mdl_blk_b;
  int         gaps_s, inrdy_low_s;
  bit         valid_prev_s, stall_s;
  int         hold_prev_s;
  int         neg_cnt_b, last_hs_neg_b, first_valid_neg_b;
  int         val_s;

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act != req) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Small-instance model and compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_s.delete();
      part_s.delete();
      mdl_blk_s    = 0;
      gaps_s       = 0;
      inrdy_low_s  = 0;
      valid_prev_s = 0;
      stall_s      = 0;
    end else begin
      check("blk_cnt_s", int'(bus_s.blk_cnt), mdl_blk_s);
      if (stall_s) begin
        check("hold_s", int'({bus_s.out_valid, bus_s.out_sof, bus_s.out_eof, bus_s.out_data}),
              hold_prev_s);
      end
      if (valid_prev_s && !bus_s.out_valid && exp_s.size() > 0) gaps_s++;
      valid_prev_s = bus_s.out_valid;
      if (bus_s.in_valid && !bus_s.in_ready) inrdy_low_s++;
      if (bus_s.out_valid && bus_s.out_ready) begin
        if (exp_s.size() == 0) begin
          check("spurious_out_s", 1, 0);
        end else begin
          e = exp_s.pop_front();
          check("out_s", int'({bus_s.out_sof, bus_s.out_eof, bus_s.out_data}),
                int'({e.sof, e.eof, e.data}));
          got_s.push_back(int'(bus_s.out_data));
          if (e.eof) mdl_blk_s = (mdl_blk_s + 1) % 65536;
        end
      end
      stall_s     = bus_s.out_valid && !bus_s.out_ready;
      hold_prev_s = int'({1'b1, bus_s.out_sof, bus_s.out_eof, bus_s.out_data});
      if (bus_s.in_valid && bus_s.in_ready) begin
        part_s.push_back(bus_s.in_data);
        if (part_s.size() == SN) begin
          for (int r = 0; r < SR; r++) begin
            for (int c = 0; c < SC; c++) begin
              e.data = part_s[c * SR + r];
              e.sof  = (r == 0) && (c == 0);
              e.eof  = (r == SR - 1) && (c == SC - 1);
              exp_s.push_back(e);
            end
          end
          part_s.delete();
        end
      end
    end
  end

  // Full-size model and compare.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt_b++;
    if (rst) begin
      exp_b.delete();
      part_b.delete();
      mdl_blk_b         = 0;
      last_hs_neg_b     = -1;
      first_valid_neg_b = -1;
    end else begin
      check("blk_cnt_b", int'(bus_b.blk_cnt), mdl_blk_b);
      if (bus_b.out_valid && first_valid_neg_b < 0) first_valid_neg_b = neg_cnt_b;
      if (bus_b.out_valid && bus_b.out_ready) begin
        if (exp_b.size() == 0) begin
          check("spurious_out_b", 1, 0);
        end else begin
          e = exp_b.pop_front();
          check("out_b", int'({bus_b.out_sof, bus_b.out_eof, bus_b.out_data}),
                int'({e.sof, e.eof, e.data}));
          if (e.eof) mdl_blk_b = (mdl_blk_b + 1) % 65536;
        end
      end
      if (bus_b.in_valid && bus_b.in_ready) begin
        part_b.push_back(bus_b.in_data);
        if (part_b.size() == BN) begin
          last_hs_neg_b = neg_cnt_b;
          for (int r = 0; r < BR; r++) begin
            for (int c = 0; c < BC; c++) begin
              e.data = part_b[c * BR + r];
              e.sof  = (r == 0) && (c == 0);
              e.eof  = (r == BR - 1) && (c == BC - 1);
              exp_b.push_back(e);
            end
          end
          part_b.delete();
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus_s.in_valid = 1'b0;
    bus_s.out_ready = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.out_ready = 1'b0;
    val_s = 0;
    got_s.delete();
    @(negedge clk);
    check("rst_outs_s", int'({bus_s.out_valid, bus_s.out_sof, bus_s.out_eof, bus_s.out_data,
                              bus_s.blk_cnt}), 0);
    check("rst_in_ready_s", int'(bus_s.in_ready), 1);
    check("rst_outs_b", int'({bus_b.out_valid, bus_b.blk_cnt}), 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Feed nwords sequential values with the given valid/ready percentages.
  task automatic drive_s(input int nwords, input int pv, input int pr, input int limit);
    int sent = 0;
    int cyc = 0;
    bus_s.in_valid  = ($urandom_range(99) < pv);
    bus_s.in_data   = 5'(val_s);
    bus_s.out_ready = ($urandom_range(99) < pr);
    while (sent < nwords && cyc < limit) begin
      @(negedge clk);
      if (bus_s.in_valid && bus_s.in_ready) begin
        sent++;
        val_s++;
      end
      @(posedge clk);
      #1;
      cyc++;
      bus_s.in_valid  = (sent < nwords) && ($urandom_range(99) < pv);
      bus_s.in_data   = 5'(val_s);
      bus_s.out_ready = ($urandom_range(99) < pr);
    end
    bus_s.in_valid = 1'b0;
    check("drive_s_done", sent, nwords);
  endtask

  task automatic drain_s(input int limit);
    bit done = 0;
    int cyc = 0;
    bus_s.in_valid  = 1'b0;
    bus_s.out_ready = 1'b1;
    while (!done && cyc < limit) begin
      @(negedge clk);
      done = (exp_s.size() == 0) && !bus_s.out_valid;
      cyc++;
    end
    check("drain_s_done", int'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lit[12] = '{0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11};
    int hs;
    bit done;
    int cyc;

    bus_s.in_valid = 1'b0;
    bus_s.in_data = '0;
    bus_s.out_ready = 1'b0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data = '0;
    bus_b.out_ready = 1'b0;
    #1;

    // T1: single block, literal transpose
    do_reset();
    check("t1_in_ready", int'(bus_s.in_ready), 1);
    drive_s(SN, 100, 100, 200);
    drain_s(200);
    check("t1_count", got_s.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < got_s.size()) check("t1_data", got_s[i], lit[i]);
    end
    check("t1_blk_cnt", int'(bus_s.blk_cnt), 1);

    // T2: three back-to-back blocks
    do_reset();
    drive_s(3 * SN, 100, 100, 200);
    drain_s(200);
    check("t2_in_ready_drops", inrdy_low_s, 0);
    check("t2_out_gaps", gaps_s, 0);
    check("t2_blk_cnt", int'(bus_s.blk_cnt), 3);

    // T3: output stalled while feeding, both banks fill
    do_reset();
    bus_s.out_ready = 1'b0;
    bus_s.in_valid  = 1'b1;
    bus_s.in_data   = 5'(val_s);
    hs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_s.in_valid && bus_s.in_ready) begin
        hs++;
        val_s++;
      end
      @(posedge clk);
      #1;
      bus_s.in_data = 5'(val_s);
    end
    check("t3_writes", hs, 24);
    check("t3_in_ready", int'(bus_s.in_ready), 0);
    check("t3_out_valid", int'(bus_s.out_valid), 1);
    check("t3_out_sof", int'(bus_s.out_sof), 1);
    check("t3_out_data", int'(bus_s.out_data), 0);
    bus_s.in_valid = 1'b0;
    drain_s(200);
    check("t3_count", got_s.size(), 24);
    for (int i = 0; i < 24; i++) begin
      if (i < got_s.size()) check("t3_data", got_s[i], lit[i % 12] + 12 * (i / 12));
    end
    check("t3_blk_cnt", int'(bus_s.blk_cnt), 2);

    // T4: random flow control over 20 blocks
    do_reset();
    drive_s(20 * SN, 50, 50, 5000);
    drain_s(1000);
    check("t4_blk_cnt", int'(bus_s.blk_cnt), 20);

    // T5: reset mid-block while the other bank drains
    do_reset();
    drive_s(2 * SN + 5, 100, 100, 300);
    check("t5_blk_pre", int'(bus_s.blk_cnt), 1);
    check("t5_draining", int'(bus_s.out_valid), 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", int'(bus_s.out_valid), 0);
    check("t5_rst_blk", int'(bus_s.blk_cnt), 0);
    check("t5_rst_in_ready", int'(bus_s.in_ready), 1);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_s(SN, 100, 100, 200);
    drain_s(200);
    check("t5_blk_post", int'(bus_s.blk_cnt), 1);

    // T6: full-size block, latency from last input to first output
    do_reset();
    hs = 0;
    cyc = 0;
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 1'b1;
    bus_b.in_data   = 5'($urandom);
    while (hs < BN && cyc < BN + 100) begin
      @(negedge clk);
      if (bus_b.in_valid && bus_b.in_ready) hs++;
      @(posedge clk);
      #1;
      cyc++;
      bus_b.in_valid = (hs < BN);
      bus_b.in_data  = 5'($urandom);
    end
    bus_b.in_valid = 1'b0;
    check("t6_writes", hs, BN);
    done = 0;
    cyc = 0;
    while (!done && cyc < BN + 100) begin
      @(negedge clk);
      done = (exp_b.size() == 0) && !bus_b.out_valid;
      cyc++;
    end
    check("t6_drain_done", int'(done), 1);
    check("t6_latency", first_valid_neg_b - last_hs_neg_b, 2);
    check("t6_blk_cnt", int'(bus_b.blk_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
